// File: rtl/pwm_capture_pkg.sv
// Shared types and width helpers for the PWM duty/period capture block.
// Defaults describe a 1200-clock PWM with a two-period stuck timeout.

package pwm_capture_pkg;

  typedef enum logic [2:0] {
    StSeek,
    StHigh,
    StLow,
    StStuckH,
    StStuckL
  } cap_state_t;

  // Duty values run 0..interval inclusive.
  function automatic int unsigned duty_width(int unsigned interval);
    return $clog2(interval + 1);
  endfunction

  // Periods can approach twice the timeout once a stuck-high phase is measured.
  function automatic int unsigned period_width(int unsigned timeout);
    return $clog2(2 * timeout);
  endfunction

  function automatic int unsigned count_width(int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned DefPwmInterval = 1200;
  localparam int unsigned DefTimeout     = 2 * DefPwmInterval;

  localparam int unsigned DW = duty_width(DefPwmInterval);
  localparam int unsigned PW = period_width(DefTimeout);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the PWM pin plus a registered level and edge detect.
// Reset parks every stage in the "off" level so no edge appears out of reset.

module sync_edge #(
  parameter bit INVERT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic level_q;
  logic level_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= INVERT;
      sync2_q      <= INVERT;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= pwm_in;
      sync2_q      <= sync1_q;
      level_q      <= sync2_q ^ INVERT;
      level_prev_q <= level_q;
    end
  end

  always_comb begin
    s    = level_q;
    rise = level_q & ~level_prev_q;
    fall = ~level_q & level_prev_q;
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures on-time and period of each PWM cycle on one pin, strobing valid per period
// and reporting constant-level inputs as stuck high/low after a timeout.

module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter bit          INVERT       = 1'b1,
  parameter int unsigned TIMEOUT      = 2 * PWM_INTERVAL
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pwm_in,
  output logic [duty_width(PWM_INTERVAL)-1:0] duty_value,
  output logic [period_width(TIMEOUT)-1:0]    period_value,
  output logic                                valid,
  output logic                                stuck_high,
  output logic                                stuck_low
);

  localparam int unsigned DutyW = duty_width(PWM_INTERVAL);
  localparam int unsigned PerW  = period_width(TIMEOUT);
  localparam int unsigned CntW  = count_width(TIMEOUT);

  localparam logic [CntW-1:0]  CntMax   = CntW'(TIMEOUT);
  localparam logic [CntW-1:0]  CntLast  = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [DutyW-1:0] DutyFull = DutyW'(PWM_INTERVAL);

  logic s;
  logic rise;
  logic fall;

  sync_edge #(
    .INVERT(INVERT)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  cap_state_t       state_q, state_d;
  logic [CntW-1:0]  hi_q, hi_d;
  logic [CntW-1:0]  lo_q, lo_d;
  logic [CntW-1:0]  hi_inc;
  logic [CntW-1:0]  lo_inc;
  logic             valid_d;
  logic [DutyW-1:0] duty_d;
  logic [PerW-1:0]  period_d;

  assign hi_inc = (hi_q == CntMax) ? hi_q : hi_q + CntOne;
  assign lo_inc = (lo_q == CntMax) ? lo_q : lo_q + CntOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSeek;
      hi_q         <= '0;
      lo_q         <= '0;
      valid        <= 1'b0;
      duty_value   <= '0;
      period_value <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      valid        <= valid_d;
      duty_value   <= duty_d;
      period_value <= period_d;
    end
  end

  // Counters hold the cycles already seen at the current level; a count of
  // TIMEOUT-1 that is not ended by an edge this cycle becomes a stuck condition.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StSeek: begin
        if (rise) begin
          state_d = StHigh;
          hi_d    = CntOne;
          lo_d    = '0;
        end else if (fall) begin
          lo_d = CntOne;
        end else begin
          lo_d = lo_inc;
          if (lo_q == CntLast) begin
            state_d = s ? StStuckH : StStuckL;
          end
        end
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          lo_d    = CntOne;
        end else begin
          hi_d = hi_inc;
          if (hi_q == CntLast) begin
            state_d = StStuckH;
          end
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
          hi_d    = CntOne;
          lo_d    = '0;
        end else begin
          lo_d = lo_inc;
          if (lo_q == CntLast) begin
            state_d = StStuckL;
          end
        end
      end
      StStuckH: begin
        if (fall) begin
          state_d = StLow;
          lo_d    = CntOne;
        end
      end
      StStuckL: begin
        if (rise) begin
          state_d = StHigh;
          hi_d    = CntOne;
          lo_d    = '0;
        end
      end
      default: state_d = StSeek;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    duty_d   = duty_value;
    period_d = period_value;
    if (state_q == StLow && rise) begin
      valid_d  = 1'b1;
      duty_d   = (32'(hi_q) > PWM_INTERVAL) ? DutyFull : DutyW'(hi_q);
      period_d = PerW'(hi_q) + PerW'(lo_q);
    end else if (state_d == StStuckH && state_q != StStuckH) begin
      valid_d  = 1'b1;
      duty_d   = DutyFull;
      period_d = '0;
    end else if (state_d == StStuckL && state_q != StStuckL) begin
      valid_d  = 1'b1;
      duty_d   = '0;
      period_d = '0;
    end
  end

  assign stuck_high = (state_q == StStuckH);
  assign stuck_low  = (state_q == StStuckL);

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Duty-cycle capture block for the RGB LED PWM path. It samples one PWM pin (by default the active-low `RGB_x` pad signal), synchronizes it, and measures the on-time and period of every PWM cycle in clock cycles. Each completed period produces a one-cycle `valid` strobe. Constant-level inputs are reported as 0 % or 100 % after a timeout. It sits on the consuming side of the LED PWM outputs, for on-chip loopback checks of the fade/pwm chain and for reading external PWM sources.

## Interface
- `PWM_INTERVAL`, 1200: nominal PWM period in clocks (100 µs at 12 MHz); also the duty saturation value.
- `INVERT`, 1: when 1, `pwm_in` low means "on" (matches the active-low LED pins); when 0, high means "on".
- `TIMEOUT`, 2*PWM_INTERVAL: clocks of constant level before a stuck condition is declared.
- Derived: `DW = $clog2(PWM_INTERVAL+1)`, `PW = $clog2(2*TIMEOUT)`.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `pwm_in` input 1: asynchronous PWM pin.
- `duty_value` output DW: measured on-cycles of the last period, clamped to PWM_INTERVAL.
- `period_value` output PW: measured period of the last completed cycle; 0 when stuck.
- `valid` output 1: one-cycle strobe when `duty_value`/`period_value` update.
- `stuck_high` output 1: level, input held "on" ≥ TIMEOUT.
- `stuck_low` output 1: level, input held "off" ≥ TIMEOUT.

## Operation
- Input conditioning:
  - Two-flop synchronizer; the flops reset to the raw value `INVERT`, so the level is "off" at reset.
  - Level `s = sync2 ^ INVERT`.
  - Previous-level flop `s_d` also resets to 0.
  - `rise = s & ~s_d`; `fall = ~s & s_d`.
- FSM states: SEEK, HIGH, LOW, STUCK_H, STUCK_L. The reset state is SEEK.
- Internal counters `hi_cnt` and `lo_cnt` are each `$clog2(TIMEOUT+1)` bits wide and saturate at TIMEOUT.
- SEEK:
  - `lo_cnt` counts cycles of constant level and clears on any level change.
  - `rise` → HIGH with `hi_cnt=1`, `lo_cnt=0`.
  - `lo_cnt` reaches TIMEOUT → STUCK_H if `s=1`, else STUCK_L.
  - No measurement is published on the first edge.
- HIGH:
  - `hi_cnt++` each cycle.
  - `fall` → LOW with `lo_cnt=1`.
  - `hi_cnt` reaches TIMEOUT → STUCK_H.
- LOW:
  - `lo_cnt++` each cycle.
  - `rise` → publish, then HIGH with `hi_cnt=1`, `lo_cnt=0`.
  - `lo_cnt` reaches TIMEOUT → STUCK_L.
- Publish (from LOW):
  - `duty_value = min(hi_cnt, PWM_INTERVAL)`.
  - `period_value = hi_cnt + lo_cnt`.
  - `valid=1` for one cycle.
- Entering STUCK_H: publish `duty_value=PWM_INTERVAL`, `period_value=0`, `valid` pulse, `stuck_high=1`.
- Entering STUCK_L: publish `duty_value=0`, `period_value=0`, `valid` pulse, `stuck_low=1`.
- STUCK_H: `fall` → LOW with `lo_cnt=1`; `stuck_high` clears the same cycle. No publish.
- STUCK_L: `rise` → HIGH with `hi_cnt=1`; `stuck_low` clears the same cycle. No publish.
- Stuck flags are mutually exclusive and are never both 1.
- Edge and timeout in the same cycle: the edge wins and no stuck condition is entered.

## Timing
- Reset: the next cycle after `rst` high, all outputs are 0 and the state is SEEK. Reset mid-operation discards partial counts.
- `duty_value` and `period_value` are registered and hold between strobes.
- Latency: an "on"-going `pwm_in` transition sampled at edge N gives `valid` high in the cycle after edge N+3 (2 sync stages, 1 `s_d` stage, 1 output register).
- Measurement is exact to ±0 cycles for pulses ≥ 1 clock. A 1-cycle pulse is captured with `hi_cnt=1`.
- Throughput: one strobe per input period, minimum period 2 clocks.
- A stuck strobe fires exactly TIMEOUT cycles after the last level change is seen at `s`.

## Structure
- Package `pwm_capture_pkg`:
  - `cap_state_t` enum (SEEK, HIGH, LOW, STUCK_H, STUCK_L).
  - Width helper localparams DW and PW, as functions of the parameters.
- Sub-module `sync_edge`: 2-flop synchronizer, INVERT XOR, `s_d` register. Outputs `s`, `rise`, `fall`. Parameter INVERT, synchronous active-high reset.
- `pwm_capture` holds the FSM, counters and output registers.

## Test plan
All scenarios use defaults: PWM_INTERVAL=1200, INVERT=1, TIMEOUT=2400.
- Reset with `pwm_in=1`, hold 10 cycles → all outputs 0, no `valid`.
- `pwm_in` low 300 / high 900, repeating → first `valid` at the second "on" edge +4 cycles; `duty_value=300`, `period_value=1200`; then one strobe every 1200 cycles.
- After reset, `pwm_in` held 1 for 2400+ cycles → one `valid` with `duty_value=0`, `period_value=0`, `stuck_low=1`. Then drive low → `stuck_low` clears, no strobe.
- `pwm_in` held 0 for 2400+ cycles → `stuck_high=1`, `duty_value=1200`. Resume 600/600 → next strobes report `duty_value=600`, `period_value=1200`.
- Duty step from 300 to 900 mid-stream, plus a 1-cycle-on/1199-off period → strobes report 900 once the step applies, and `duty_value=1` for the 1-cycle pulse.
- Assert `rst` during an "on" phase at cycle 150 → outputs 0 the next cycle; no `valid` until two "on" edges have been seen.
